tawas_thread_sched: RTL
=======================

Name: tawas_thread_sched

Overview:
Parametrised thread scheduler and PC bank for the next-generation tawas core. It replaces the fixed 1-bit SLICE toggle with a round-robin issue slot over THREADS hardware threads. Each thread has its own PC, enable bit, block/wake state and minimum re-issue spacing. It sits between the fetch stage, which consumes IADDR and SLICE, and the execute/load-store stages, which return PC redirects and block/wake events.

Parameters:
THREAD_BITS, 2, thread-id width; THREADS = 2**THREAD_BITS
PC_W, 24, program counter / IADDR width
RESET_VEC, 0, PC value loaded into every thread at reset
MIN_GAP, 2, minimum cycles between two issues of the same thread (1 = back-to-back allowed)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-low; asserted when 0
THREAD_EN  in  THREADS  per-thread enable; bit i=0 makes thread i ineligible
ISSUE_VLD  out  1  registered; an issue slot is valid this cycle
SLICE  out  THREAD_BITS  registered; thread id of the current issue
IADDR  out  PC_W  registered; fetch address of the issued thread
PC_RTN  out  PC_W  registered; IADDR+1, the return address for call ops
PC_STORE  in  1  PC redirect strobe
PC_STORE_SEL  in  THREAD_BITS  thread being redirected
PC  in  PC_W  redirect target
BLOCK_VLD  in  1  put a thread to sleep (load outstanding)
BLOCK_SEL  in  THREAD_BITS  thread to block
WAKE_VLD  in  1  wake a blocked thread (load data returned)
WAKE_SEL  in  THREAD_BITS  thread to wake

Behaviour:
- Reset (RST=0, async): pc[i]=RESET_VEC; blocked[i]=0; gap counters=0; last-issued pointer=THREADS-1; ISSUE_VLD=0, SLICE=0, IADDR=RESET_VEC, PC_RTN=RESET_VEC+1.
- Per-thread state: pc[i]; blocked[i]; gap_cnt[i], a counter of width clog2(MIN_GAP+1).
- Eligible(i) = THREAD_EN[i] & ~blocked[i] & (gap_cnt[i]==0).
- Arbitration: round-robin. Search starts at last-issued+1 and wraps modulo THREADS. The first eligible thread wins. One issue per cycle at most.
- On issue of thread w at edge t:
  - ISSUE_VLD=1, SLICE=w, IADDR=pc[w], PC_RTN=pc[w]+1, all visible after the edge.
  - pc[w] becomes pc[w]+1, wrapping modulo 2**PC_W.
  - gap_cnt[w] becomes MIN_GAP-1.
  - Last-issued pointer becomes w.
- No eligible thread: ISSUE_VLD=0; SLICE, IADDR and PC_RTN hold their previous values; pointer unchanged.
- gap_cnt of every non-issued thread decrements toward 0 each cycle, saturating at 0.
- PC_STORE: pc[PC_STORE_SEL] becomes PC on the next edge. If the same thread is issued in the same cycle, PC_STORE wins over the +1 increment. The issue still uses the old pc value.
- BLOCK_VLD sets blocked[BLOCK_SEL]; WAKE_VLD clears blocked[WAKE_SEL].
  - Block and wake on the same thread in the same cycle: wake wins, thread ends unblocked.
  - Eligibility uses registered state only. A thread blocked this cycle can still be issued this cycle; the block takes effect next cycle.
- WAKE on a thread that is not blocked: no effect. BLOCK on a thread that is already blocked: no effect.
- THREAD_EN deasserted: pc, blocked and gap_cnt are retained and gap_cnt keeps counting. The thread resumes from its retained pc when re-enabled.
- Latency: THREAD_EN or wake to first possible issue is 1 cycle. PC_STORE to fetch of the new target is 1 cycle, if the thread wins arbitration.
- Async reset mid-operation: all state returns to reset values immediately. There is no partial-issue output.

Decomposition:
- tawas_pkg holds:
  - localparam THREADS derivation;
  - a clog2 function;
  - the gap counter width;
  - a thread-id typedef;
  - the RESET_VEC default.
- One sub-module, tawas_rr_arb: combinational round-robin priority pick. It takes a THREADS request vector and a last pointer, and returns grant-valid and a grant id. It is reused later for the load-store port arbiter.
- PC bank, blocked flags, gap counters and output registers stay in tawas_thread_sched.

Test Plan:
- Reset with THREAD_EN=4'hF, MIN_GAP=2, THREAD_BITS=2 -> SLICE sequence 0,1,2,3,0,…; IADDR of thread 0 is 0, then 1 on its second issue; ISSUE_VLD=1 every cycle.
- MIN_GAP=2, THREAD_EN=4'b0001 -> thread 0 issues every other cycle; ISSUE_VLD pattern 1,0,1,0; IADDR 0,1,2.
- BLOCK_VLD thread 1 at cycle 5, WAKE_VLD thread 1 at cycle 12 -> thread 1 is absent from SLICE from cycle 6 until after 12, then rejoins at its correct pc; block and wake of thread 1 in the same cycle -> no gap in thread 1 issues.
- PC_STORE thread 2 to 24'h000100 in the cycle thread 2 issues -> that issue shows the old pc; the next thread 2 issue shows IADDR=24'h000100 and PC_RTN=24'h000101.
- Thread 3 pc at 24'hFFFFFF, issue -> IADDR=24'hFFFFFF, PC_RTN=24'h000000, next thread 3 IADDR=0.
- Assert RST low mid-stream with threads blocked -> outputs and state return immediately to reset values; after release the sequence restarts at SLICE=0 with all threads unblocked.

Source files
------------

// File: rtl/tawas_pkg.sv
// Shared definitions for the tawas thread scheduler: default geometry,
// width helpers and the thread-id type.
package tawas_pkg;

  localparam int THREAD_BITS_DEF = 2;
  localparam int PC_W_DEF        = 24;
  localparam int MIN_GAP_DEF     = 2;
  localparam logic [PC_W_DEF-1:0] RESET_VEC_DEF = '0;

  function automatic int threads_of(input int thread_bits);
    return 1 << thread_bits;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Gap counter must hold MIN_GAP-1; never let it collapse to zero width.
  function automatic int gap_width(input int min_gap);
    int w;
    w = clog2(min_gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int THREADS_DEF = threads_of(THREAD_BITS_DEF);
  localparam int GAP_W_DEF   = gap_width(MIN_GAP_DEF);

  typedef logic [THREAD_BITS_DEF-1:0] tid_t;

endpackage

// File: rtl/tawas_thread_sched_if.sv
// Bundle between the scheduler, the fetch stage and the execute/load-store
// stages. The scheduler side uses the master modport.
interface tawas_thread_sched_if #(
    parameter int THREAD_BITS = 2,
    parameter int PC_W        = 24
);
    localparam int THREADS = 1 << THREAD_BITS;

    // ISSUE_VLD qualifies SLICE/IADDR/PC_RTN for exactly one cycle; fetch has
    // no ready/backpressure, so every valid cycle is a consumed issue. The
    // PC_STORE, BLOCK_VLD and WAKE_VLD strobes are single-cycle events taken
    // on the rising edge where they are high, with no acknowledge.
    logic [THREADS-1:0]     THREAD_EN;
    logic                   ISSUE_VLD;
    logic [THREAD_BITS-1:0] SLICE;
    logic [PC_W-1:0]        IADDR;
    logic [PC_W-1:0]        PC_RTN;
    logic                   PC_STORE;
    logic [THREAD_BITS-1:0] PC_STORE_SEL;
    logic [PC_W-1:0]        PC;
    logic                   BLOCK_VLD;
    logic [THREAD_BITS-1:0] BLOCK_SEL;
    logic                   WAKE_VLD;
    logic [THREAD_BITS-1:0] WAKE_SEL;

    modport master (
        input  THREAD_EN,
        input  PC_STORE, PC_STORE_SEL, PC,
        input  BLOCK_VLD, BLOCK_SEL,
        input  WAKE_VLD, WAKE_SEL,
        output ISSUE_VLD, SLICE, IADDR, PC_RTN
    );

    modport slave (
        output THREAD_EN,
        output PC_STORE, PC_STORE_SEL, PC,
        output BLOCK_VLD, BLOCK_SEL,
        output WAKE_VLD, WAKE_SEL,
        input  ISSUE_VLD, SLICE, IADDR, PC_RTN
    );

endinterface

// File: rtl/tawas_rr_arb.sv
// Combinational round-robin pick: the search starts one past last_i and
// wraps, the first requester found wins.
module tawas_rr_arb #(
    parameter int ID_W = 2
) (
    input  logic [(1<<ID_W)-1:0] req_i,
    input  logic [ID_W-1:0]      last_i,
    output logic                 gnt_vld_o,
    output logic [ID_W-1:0]      gnt_id_o
);

    localparam int N = 1 << ID_W;

    logic [ID_W-1:0] idx;

    // Offset N wraps back to last_i itself, so the previous winner is
    // considered last.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_id_o  = last_i;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = last_i + ID_W'(k);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_id_o  = idx;
            end
        end
    end

endmodule

// File: rtl/tawas_thread_sched.sv
// Round-robin issue slot and per-thread PC bank with block/wake state and a
// minimum re-issue spacing per thread.
module tawas_thread_sched
    import tawas_pkg::*;
#(
    parameter int              THREAD_BITS = THREAD_BITS_DEF,
    parameter int              PC_W        = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(RESET_VEC_DEF),
    parameter int              MIN_GAP     = MIN_GAP_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    tawas_thread_sched_if.master  bus
);

    localparam int THREADS = threads_of(THREAD_BITS);
    localparam int GAP_W   = gap_width(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

    logic [PC_W-1:0]        pc_q    [THREADS];
    logic [PC_W-1:0]        pc_d    [THREADS];
    logic [GAP_W-1:0]       gap_q   [THREADS];
    logic [GAP_W-1:0]       gap_d   [THREADS];
    logic [THREADS-1:0]     blocked_q, blocked_d;
    logic [THREAD_BITS-1:0] last_q, last_d;

    logic                   issue_vld_q, issue_vld_d;
    logic [THREAD_BITS-1:0] slice_q, slice_d;
    logic [PC_W-1:0]        iaddr_q, iaddr_d;
    logic [PC_W-1:0]        pc_rtn_q, pc_rtn_d;

    logic [THREADS-1:0]     eligible;
    logic                   gnt_vld;
    logic [THREAD_BITS-1:0] gnt_id;
    logic [PC_W-1:0]        win_pc;

    // Eligibility looks only at registered state, so a block strobe in the
    // current cycle cannot cancel the issue already being chosen.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < THREADS; i++) begin
            eligible[i] = bus.THREAD_EN[i] & ~blocked_q[i] & (gap_q[i] == '0);
        end
    end

    tawas_rr_arb #(
        .ID_W (THREAD_BITS)
    ) u_arb (
        .req_i     (eligible),
        .last_i    (last_q),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    assign win_pc = pc_q[gnt_id];

    always_comb begin
        blocked_d = blocked_q;
        last_d    = last_q;
        for (int i = 0; i < THREADS; i++) begin
            pc_d[i]  = pc_q[i];
            gap_d[i] = gap_q[i];

            if (gnt_vld && (gnt_id == THREAD_BITS'(i))) begin
                gap_d[i] = GAP_RELOAD;
            end else if (gap_q[i] != '0) begin
                gap_d[i] = gap_q[i] - GAP_W'(1);
            end

            // A redirect overrides the post-issue increment of the same thread.
            if (bus.PC_STORE && (bus.PC_STORE_SEL == THREAD_BITS'(i))) begin
                pc_d[i] = bus.PC;
            end else if (gnt_vld && (gnt_id == THREAD_BITS'(i))) begin
                pc_d[i] = pc_q[i] + PC_W'(1);
            end

            if (bus.BLOCK_VLD && (bus.BLOCK_SEL == THREAD_BITS'(i))) begin
                blocked_d[i] = 1'b1;
            end
            if (bus.WAKE_VLD && (bus.WAKE_SEL == THREAD_BITS'(i))) begin
                blocked_d[i] = 1'b0;
            end
        end
        if (gnt_vld) begin
            last_d = gnt_id;
        end
    end

    // Fetch-facing outputs hold their last issue when the slot goes idle.
    always_comb begin
        issue_vld_d = gnt_vld;
        slice_d     = slice_q;
        iaddr_d     = iaddr_q;
        pc_rtn_d    = pc_rtn_q;
        if (gnt_vld) begin
            slice_d  = gnt_id;
            iaddr_d  = win_pc;
            pc_rtn_d = win_pc + PC_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < THREADS; i++) begin
                pc_q[i]  <= RESET_VEC;
                gap_q[i] <= '0;
            end
            blocked_q   <= '0;
            last_q      <= THREAD_BITS'(THREADS - 1);
            issue_vld_q <= 1'b0;
            slice_q     <= '0;
            iaddr_q     <= RESET_VEC;
            pc_rtn_q    <= RESET_VEC + PC_W'(1);
        end else begin
            for (int i = 0; i < THREADS; i++) begin
                pc_q[i]  <= pc_d[i];
                gap_q[i] <= gap_d[i];
            end
            blocked_q   <= blocked_d;
            last_q      <= last_d;
            issue_vld_q <= issue_vld_d;
            slice_q     <= slice_d;
            iaddr_q     <= iaddr_d;
            pc_rtn_q    <= pc_rtn_d;
        end
    end

    assign bus.ISSUE_VLD = issue_vld_q;
    assign bus.SLICE     = slice_q;
    assign bus.IADDR     = iaddr_q;
    assign bus.PC_RTN    = pc_rtn_q;

endmodule
